// File: rtl/branch_fetch_sequencer.sv
// branch_fetch_sequencer: instruction fetch and branch-resolution sequencer.
// Owns PC and IR. It fetches a word, decodes its opcode, and then does one of two things:
// - For a conditional branch, it enables the CON flip-flop for one cycle and then
//   redirects PC if the condition is true.
// - For any other instruction, it hands the instruction to the execute controller.
// Optional build macro BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module branch_fetch_sequencer #(
  parameter logic [4:0]  BR_OPCODE   = 5'b10010,
  parameter logic [4:0]  HALT_OPCODE = 5'b11011,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        run,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  input  logic        con_ff,
  input  logic        exec_done,
  output logic [31:0] pc,
  output logic [31:0] mar_addr,
  output logic        mem_read,
  output logic [31:0] ir_out,
  output logic [3:0]  ra_sel,
  output logic        con_in,
  output logic        exec_start,
  output logic        branch_taken,
  output logic        halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_count,
  output logic [15:0] not_taken_count
`endif
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FETCH      = 3'd1;
  localparam logic [2:0] S_WAIT       = 3'd2;
  localparam logic [2:0] S_DECODE     = 3'd3;
  localparam logic [2:0] S_BR_EVAL    = 3'd4;
  localparam logic [2:0] S_BR_RESOLVE = 3'd5;
  localparam logic [2:0] S_EXEC       = 3'd6;
  localparam logic [2:0] S_HALT       = 3'd7;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [4:0]  opcode;
  logic [31:0] branch_offset;

  assign opcode        = ir_out[31:27];
  // The offset is relative to the PC that was already incremented during the load.
  assign branch_offset = {{13{ir_out[18]}}, ir_out[18:0]};

  // Next-state selection for the fetch / decode / branch / execute sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (run) state_next = S_FETCH;
      S_FETCH:      state_next = S_WAIT;
      S_WAIT:       if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == BR_OPCODE)        state_next = S_BR_EVAL;
        else if (opcode == HALT_OPCODE) state_next = S_HALT;
        else                            state_next = S_EXEC;
      end
      S_BR_EVAL:    state_next = S_BR_RESOLVE;
      S_BR_RESOLVE: state_next = run ? S_FETCH : S_IDLE;
      S_EXEC:       if (exec_done) state_next = run ? S_FETCH : S_IDLE;
      S_HALT:       state_next = S_HALT;
      default:      state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // PC, IR and MAR updates: MAR latches at fetch, IR and PC+1 at load, and the redirect happens at resolve.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pc       <= RESET_PC;
      ir_out   <= 32'h0000_0000;
      mar_addr <= 32'h0000_0000;
    end else begin
      if (state == S_FETCH) mar_addr <= pc;
      if (state == S_WAIT && mem_ready) begin
        ir_out <= mem_data;
        pc     <= pc + 32'd1;
      end
      if (state == S_BR_RESOLVE && con_ff) pc <= pc + branch_offset;
    end
  end

  // Strobes decoded from the current state; branch_taken follows con_ff during resolve.
  always_comb begin
    mem_read     = (state == S_FETCH) || (state == S_WAIT);
    con_in       = (state == S_BR_EVAL);
    ra_sel       = (state == S_BR_EVAL) ? ir_out[26:23] : 4'd0;
    exec_start   = (state == S_DECODE) && (opcode != BR_OPCODE) && (opcode != HALT_OPCODE);
    branch_taken = (state == S_BR_RESOLVE) && con_ff;
    halted       = (state == S_HALT);
  end

`ifdef BRANCH_STATS_EN
  // Saturating counters for resolved branches, split by outcome.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      taken_count     <= 16'h0000;
      not_taken_count <= 16'h0000;
    end else if (state == S_BR_RESOLVE) begin
      if (con_ff) begin
        if (taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
      end else begin
        if (not_taken_count != 16'hFFFF) not_taken_count <= not_taken_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_fetch_sequencer.sv
// Testbench for branch_fetch_sequencer.
// It runs three kinds of checks:
// - a table of directed instructions;
// - random instructions, checked against a PC reference model;
// - hand-written run-drop, halt, reset and statistics sequences.
module tb_branch_fetch_sequencer;

  localparam logic [4:0] BR   = 5'b10010;
  localparam logic [4:0] HALT = 5'b11011;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        run;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        con_ff;
  logic        exec_done;
  logic [31:0] pc;
  logic [31:0] mar_addr;
  logic        mem_read;
  logic [31:0] ir_out;
  logic [3:0]  ra_sel;
  logic        con_in;
  logic        exec_start;
  logic        branch_taken;
  logic        halted;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count;
  logic [15:0] not_taken_count;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] modelPc;
  int          expTakenCnt;
  int          expNotTakenCnt;

  typedef struct {
    logic [31:0] instr;
    logic        con;
    int          readyDelay;
    int          doneDelay;
    logic [31:0] expPc;
    logic        expTaken;
  } vec_t;

  vec_t vectors[14];

  branch_fetch_sequencer dut (
    .clock(clock), .clear_n(clear_n), .run(run), .mem_data(mem_data),
    .mem_ready(mem_ready), .con_ff(con_ff), .exec_done(exec_done),
    .pc(pc), .mar_addr(mar_addr), .mem_read(mem_read), .ir_out(ir_out),
    .ra_sel(ra_sel), .con_in(con_in), .exec_start(exec_start),
    .branch_taken(branch_taken), .halted(halted)
`ifdef BRANCH_STATS_EN
    , .taken_count(taken_count), .not_taken_count(not_taken_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference PC rule: the next sequential word, plus the signed 19-bit offset when a branch is taken.
  function automatic logic [31:0] refNextPc(input logic [31:0] p, input logic [31:0] instr, input logic con);
    longint off;
    off = longint'(instr[18:0]);
    if (instr[18]) off = off - 64'd524288;
    if (instr[31:27] == BR && con) return p + 32'd1 + off[31:0];
    return p + 32'd1;
  endfunction

  // Serve one instruction to the DUT and check everything that happens until the next fetch, idle or halt.
  task automatic applyStimulus(input logic [31:0] instr, input logic con, input int readyDelay,
                               input int doneDelay, input bit runDuring, input logic [31:0] pcBefore,
                               input logic [31:0] expPc, input logic expTaken);
    bit isBr, isHalt, done, fetchSeen, inResolve, lastConIn;
    int startCnt, conCnt, takenCnt, haltCnt, sinceStart;
    isBr = (instr[31:27] == BR);
    isHalt = (instr[31:27] == HALT);
    for (int k = 0; k < 20 && mem_read !== 1'b1; k++) @(negedge clock);
    checkOutput("fetch_request", mem_read, 1'b1);
    if (mem_read !== 1'b1) return;
    // FETCH cycle: a stray ready with garbage data must be ignored.
    mem_ready = 1'($urandom % 2);
    mem_data = $urandom;
    @(negedge clock);
    mem_ready = 1'b0;
    checkOutput("mar_addr", mar_addr, pcBefore);
    checkOutput("wait_mem_read", mem_read, 1'b1);
    repeat (readyDelay) begin
      mem_data = $urandom;
      @(negedge clock);
    end
    mem_ready = 1'b1;
    mem_data = instr;
    @(negedge clock);
    mem_ready = 1'b0;
    mem_data = $urandom;
    checkOutput("ir_load", ir_out, instr);
    checkOutput("pc_increment", pc, pcBefore + 32'd1);
    run = runDuring;
    startCnt = 0; conCnt = 0; takenCnt = 0; haltCnt = 0;
    sinceStart = -1; done = 0; fetchSeen = 0; lastConIn = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      inResolve = lastConIn;
      if (exec_start) begin startCnt++; sinceStart = 0; end
      else if (sinceStart >= 0) sinceStart++;
      if (con_in) begin
        conCnt++;
        checkOutput("ra_sel_eval", ra_sel, instr[26:23]);
      end else checkOutput("ra_sel_other", ra_sel, 4'd0);
      if (branch_taken) takenCnt++;
      if (halted) haltCnt++;
      lastConIn = con_in;
      if (mem_read) begin done = 1; fetchSeen = 1; end
      else if (isHalt && haltCnt >= 6) done = 1;
      else if (!runDuring && !isHalt && i >= 12 + doneDelay) done = 1;
      if (!done) begin
        con_ff = (con_in || inResolve) ? con : 1'($urandom % 2);
        if (sinceStart >= 1) exec_done = (sinceStart - 1 == doneDelay);
        else exec_done = 1'($urandom % 2);
        @(negedge clock);
      end
    end
    exec_done = 1'b0;
    checkOutput("next_fetch", fetchSeen, runDuring && !isHalt);
    checkOutput("exec_start_count", startCnt, (!isBr && !isHalt) ? 1 : 0);
    checkOutput("con_in_count", conCnt, isBr ? 1 : 0);
    checkOutput("branch_taken_count", takenCnt, expTaken ? 1 : 0);
    checkOutput("halted_seen", haltCnt > 0, isHalt);
    checkOutput("pc_final", pc, expPc);
    if (isBr) begin
      if (con) expTakenCnt++;
      else expNotTakenCnt++;
    end
  endtask

  // Assert clear_n between clock edges and confirm that the outputs clear without waiting for a clock edge.
  task automatic asyncReset(input string tag);
    #2;
    clear_n = 1'b0;
    #1;
    checkOutput({tag, "_pc"}, pc, 32'd0);
    checkOutput({tag, "_ir"}, ir_out, 32'd0);
    checkOutput({tag, "_mar"}, mar_addr, 32'd0);
    checkOutput({tag, "_strobes"}, {mem_read, con_in, exec_start, branch_taken, halted}, 5'd0);
    run = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    modelPc = 32'd0;
    expTakenCnt = 0;
    expNotTakenCnt = 0;
  endtask

  initial begin
    logic [31:0] instr, expPc;
    logic [4:0]  opc;
    logic        con;

    vectors[0]  = '{32'h0800_0000, 1'b0, 1, 0, 32'd1, 1'b0};
    vectors[1]  = '{32'h0800_0001, 1'b0, 0, 2, 32'd2, 1'b0};
    vectors[2]  = '{32'h4123_4567, 1'b1, 3, 1, 32'd3, 1'b0};
    vectors[3]  = '{32'h9800_0010, 1'b1, 0, 0, 32'd4, 1'b0};
    vectors[4]  = '{32'h0000_0000, 1'b0, 1, 3, 32'd5, 1'b0};
    vectors[5]  = '{32'h9000_0010, 1'b1, 1, 0, 32'd22, 1'b1};
    vectors[6]  = '{{BR, 4'd3, 4'd0, 19'h7FFF3}, 1'b1, 0, 0, 32'd10, 1'b1};
    vectors[7]  = '{{BR, 4'd9, 4'd5, 19'h7FFFC}, 1'b1, 2, 0, 32'd7, 1'b1};
    vectors[8]  = '{{BR, 4'hF, 4'd0, 19'd100}, 1'b0, 0, 0, 32'd8, 1'b0};
    vectors[9]  = '{{5'b10011, 27'h7FF_FFFF}, 1'b1, 0, 1, 32'd9, 1'b0};
    vectors[10] = '{{BR, 4'd1, 4'd0, 19'h40000}, 1'b1, 1, 0, 32'hFFFC_000A, 1'b1};
    vectors[11] = '{{BR, 4'd2, 4'd0, 19'h3FFFF}, 1'b1, 0, 0, 32'h0000_000A, 1'b1};
    vectors[12] = '{{BR, 4'd0, 4'd0, 19'h7FFF4}, 1'b1, 0, 0, 32'hFFFF_FFFF, 1'b1};
    vectors[13] = '{32'h1000_0000, 1'b0, 1, 0, 32'h0000_0000, 1'b0};

    clear_n = 1'b0; run = 1'b0; mem_data = 32'd0; mem_ready = 1'b0;
    con_ff = 1'b0; exec_done = 1'b0;
    expTakenCnt = 0; expNotTakenCnt = 0; modelPc = 32'd0;
    #3;
    checkOutput("reset_pc", pc, 32'd0);
    checkOutput("reset_ir", ir_out, 32'd0);
    checkOutput("reset_mar", mar_addr, 32'd0);
    checkOutput("reset_strobes", {mem_read, con_in, exec_start, branch_taken, halted, ra_sel}, 9'd0);
    @(negedge clock);
    clear_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("idle_without_run", mem_read, 1'b0);
    end
    run = 1'b1;

    $display("[TB] directed vector table");
    for (int v = 0; v < 14; v++) begin
      applyStimulus(vectors[v].instr, vectors[v].con, vectors[v].readyDelay, vectors[v].doneDelay,
                    1'b1, modelPc, vectors[v].expPc, vectors[v].expTaken);
      modelPc = vectors[v].expPc;
    end

    $display("[TB] randomized instructions against reference model");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 4) opc = BR;
      else begin
        opc = 5'($urandom_range(0, 31));
        if (opc == BR || opc == HALT) opc = 5'b00001;
      end
      instr = {opc, 27'($urandom)};
      con = 1'($urandom % 2);
      expPc = refNextPc(modelPc, instr, con);
      applyStimulus(instr, con, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, modelPc,
                    expPc, (opc == BR) && con);
      modelPc = expPc;
    end
`ifdef BRANCH_STATS_EN
    checkOutput("stats_taken_random", taken_count, 32'(expTakenCnt));
    checkOutput("stats_not_taken_random", not_taken_count, 32'(expNotTakenCnt));
`endif

    $display("[TB] run dropped mid-instruction");
    expPc = refNextPc(modelPc, 32'h2000_0005, 1'b0);
    applyStimulus(32'h2000_0005, 1'b0, 1, 2, 1'b0, modelPc, expPc, 1'b0);
    modelPc = expPc;
    run = 1'b1;
    instr = {BR, 4'd7, 4'd0, 19'd3};
    expPc = refNextPc(modelPc, instr, 1'b1);
    applyStimulus(instr, 1'b1, 0, 0, 1'b0, modelPc, expPc, 1'b1);
    modelPc = expPc;
    run = 1'b1;
    expPc = refNextPc(modelPc, 32'h3000_0000, 1'b0);
    applyStimulus(32'h3000_0000, 1'b0, 0, 0, 1'b1, modelPc, expPc, 1'b0);
    modelPc = expPc;

    $display("[TB] halt then asynchronous reset");
    applyStimulus(32'hD800_0000, 1'b0, 1, 0, 1'b1, modelPc, modelPc + 32'd1, 1'b0);
    checkOutput("halt_holds", {halted, mem_read}, 2'b10);
    asyncReset("halt_reset");

    $display("[TB] asynchronous reset while waiting on memory");
    run = 1'b1;
    applyStimulus(32'h0800_0000, 1'b0, 0, 0, 1'b1, 32'd0, 32'd1, 1'b0);
    @(negedge clock);
    checkOutput("wait_before_reset", {mem_read, mar_addr}, {1'b1, 32'd1});
    asyncReset("wait_reset");
    run = 1'b1;
    applyStimulus(32'h0800_0000, 1'b0, 0, 0, 1'b1, 32'd0, 32'd1, 1'b0);
    modelPc = 32'd1;

`ifdef BRANCH_STATS_EN
    $display("[TB] branch statistics");
    @(negedge clock);
    asyncReset("stats_reset");
    run = 1'b1;
    for (int b = 0; b < 5; b++) begin
      con = (b % 2 == 0);
      instr = {BR, 4'd0, 4'd0, 19'd1};
      expPc = refNextPc(modelPc, instr, con);
      applyStimulus(instr, con, 0, 0, 1'b1, modelPc, expPc, con);
      modelPc = expPc;
    end
    checkOutput("stats_taken_3", taken_count, 32'd3);
    checkOutput("stats_not_taken_2", not_taken_count, 32'd2);
    force dut.taken_count = 16'hFFFF;
    @(negedge clock);
    release dut.taken_count;
    instr = {BR, 4'd0, 4'd0, 19'd1};
    expPc = refNextPc(modelPc, instr, 1'b1);
    applyStimulus(instr, 1'b1, 0, 0, 1'b1, modelPc, expPc, 1'b1);
    checkOutput("stats_saturate", taken_count, 32'h0000_FFFF);
    checkOutput("stats_not_taken_hold", not_taken_count, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_fetch_sequencer.md
Name: branch_fetch_sequencer

Overview:
- Instruction fetch and branch-resolution sequencer; owns PC and IR and sits directly upstream of the CON flip-flop logic.
- Fetches words from memory, loads IR, and for branch opcodes drives the Ra select and the CON-FF enable for one cycle.
- On the following cycle it consumes the CON output and updates PC as taken or not-taken.
- Non-branch opcodes are handed to the execute controller through a start/done handshake.

Parameters:
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a conditional branch.
- HALT_OPCODE, 5'b11011, IR[31:27] value that stops sequencing.
- RESET_PC, 32'h0000_0000, PC value on reset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- run  in  1  level; leaving IDLE requires run=1.
- mem_data  in  32  read data from memory.
- mem_ready  in  1  read-complete strobe; mem_data is valid in the cycle it is high.
- con_ff  in  1  CON flip-flop output (branch condition).
- exec_done  in  1  execute controller finished the non-branch instruction.
- pc  out  32  program counter.
- mar_addr  out  32  memory address for fetch.
- mem_read  out  1  fetch request.
- ir_out  out  32  instruction register, feeds CON logic and decode.
- ra_sel  out  4  register-file read select, drives Ra onto the bus.
- con_in  out  1  CON-FF enable.
- exec_start  out  1  one-cycle pulse handing a non-branch instruction to execute.
- branch_taken  out  1  one-cycle pulse when PC is redirected.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (clear_n=0, asynchronous): state=IDLE, pc=RESET_PC, ir_out=0, mar_addr=0, all strobes=0, halted=0.
- ra_sel is combinational: IR[26:23] in BR_EVAL, else 0.
- IDLE: go to FETCH when run=1.
- FETCH: mar_addr<=pc, mem_read=1; go to WAIT.
- WAIT: hold mem_read=1 until mem_ready=1, with no timeout.
  - On mem_ready=1: ir_out<=mem_data, pc<=pc+1 (wraps 32'hFFFF_FFFF to 0); go to DECODE.
  - A mem_ready that arrives in FETCH is ignored.
- DECODE, by IR[31:27]:
  - BR_OPCODE: go to BR_EVAL.
  - HALT_OPCODE: go to HALT.
  - Otherwise: exec_start=1 (Moore, one cycle); go to EXEC.
- BR_EVAL: con_in=1 for exactly this cycle; go to BR_RESOLVE.
- BR_RESOLVE: sample con_ff.
  - con_ff=1: pc<=pc+sext(IR[18:0]) (19-bit two's-complement, sign-extended to 32, modulo 2^32) and branch_taken=1.
  - con_ff=0: pc unchanged.
  - Next state: FETCH if run=1, else IDLE.
- EXEC: wait for exec_done=1; then FETCH if run=1, else IDLE.
  - exec_done in any other state is ignored.
- HALT: halted=1; stay until clear_n is asserted (run is ignored).
- Branch latency: mem_ready to PC redirect = 3 cycles (LOAD edge, DECODE, BR_EVAL, update at the BR_RESOLVE edge).
- Offset is relative to the already-incremented PC.
- run dropping mid-instruction completes the current instruction before returning to IDLE.
- Reset mid-operation aborts immediately; no partial PC/IR update survives.

Optional Feature:
- BRANCH_STATS_EN: adds outputs taken_count[15:0] and not_taken_count[15:0].
  - Each increments in BR_RESOLVE according to con_ff and saturates at 16'hFFFF.
  - Both cleared by clear_n.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset/fetch: clear_n pulse, run=1, mem_ready 2 cycles after mem_read, mem_data=32'h0800_0000 (non-branch) -> mar_addr=0, ir_out=32'h0800_0000, pc=1, exec_start single pulse; after exec_done the next fetch is at mar_addr=1.
- Branch taken, positive offset: pc=5, fetch 32'h9000_0010 (BR, C=16), con_ff=1 in BR_RESOLVE -> con_in high exactly one cycle, ra_sel=0 in BR_EVAL, pc=6+16=22, branch_taken pulse.
- Branch taken, negative offset: fetch with IR[18:0]=19'h7FFFC (-4) at pc=10 -> pc=11-4=7.
- Branch not taken: con_ff=0 -> pc=pc_old+1, no branch_taken, next mar_addr=pc_old+1.
- Halt and reset: fetch 32'hD800_0000 -> halted=1 and no further mem_read even with run=1; clear_n asserted in WAIT -> all outputs return to reset values immediately, independent of clock.
- With BRANCH_STATS_EN: 3 taken plus 2 not-taken branches -> taken_count=3, not_taken_count=2; force taken_count to 16'hFFFF, one more taken branch -> stays 16'hFFFF.
